// File: rtl/state_sequencer.sv
// Sequencer that steps the 6-bit state bus decoded by control_unit into
// the control word: idle -> fetch1..fetch6 -> execute states -> fetch1.
//
// Ports:
//   clock       in   system clock, all state changes on posedge
//   reset       in   asynchronous, active-high
//   start       in   begin execution from idle (level sampled)
//   opcode      in   IR contents, sampled on the edge leaving fetch6
//   mem_ready   in   memory read complete, only consulted in fetch2
//   state       out  current state code
//   busy        out  state != idle
//   done        out  one-cycle pulse after an END opcode
//   illegal     out  sticky flag for an undecodable opcode
//   instr_count out  non-END instructions dispatched since start
module state_sequencer #(
  parameter int COUNT_W  = 16,
  parameter bit STALL_EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         opcode,
  input  logic               mem_ready,
  output logic [5:0]         state,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [5:0] S_IDLE  = 6'd0;
  localparam logic [5:0] S_F1    = 6'd1;
  localparam logic [5:0] S_F2    = 6'd2;
  localparam logic [5:0] S_F3    = 6'd3;
  localparam logic [5:0] S_F4    = 6'd4;
  localparam logic [5:0] S_F5    = 6'd5;
  localparam logic [5:0] S_F6    = 6'd6;
  localparam logic [5:0] S_LDR11 = 6'd7;
  localparam logic [5:0] S_LDR12 = 6'd8;
  localparam logic [5:0] S_LDR13 = 6'd9;
  localparam logic [5:0] S_LDR14 = 6'd10;
  localparam logic [5:0] S_LDR21 = 6'd11;
  localparam logic [5:0] S_LDR22 = 6'd12;
  localparam logic [5:0] S_LDR23 = 6'd13;
  localparam logic [5:0] S_LDR24 = 6'd14;
  localparam logic [5:0] S_STAC1 = 6'd15;
  localparam logic [5:0] S_STAC2 = 6'd16;
  localparam logic [5:0] S_STAC3 = 6'd17;
  localparam logic [5:0] S_STAC4 = 6'd18;
  localparam logic [5:0] S_ADD   = 6'd19;
  localparam logic [5:0] S_ADD2  = 6'd20;
  localparam logic [5:0] S_MUL   = 6'd21;

  localparam logic [7:0] OP_END  = 8'h00;
  localparam logic [7:0] OP_LDR1 = 8'h01;
  localparam logic [7:0] OP_LDR2 = 8'h02;
  localparam logic [7:0] OP_STAC = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_MUL  = 8'h05;

  logic [5:0]         state_q, state_d;
  logic               done_q, done_d;
  logic               ill_q, ill_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               fetch_go;

  assign fetch_go = mem_ready || !STALL_EN;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_F1;
          ill_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_F1:    state_d = S_F2;
      S_F2:    state_d = fetch_go ? S_F3 : S_F2;
      S_F3:    state_d = S_F4;
      S_F4:    state_d = S_F5;
      S_F5:    state_d = S_F6;
      S_F6: begin
        // Every dispatched opcode bumps the counter; END and
        // unknown opcodes fall back to idle without counting.
        cnt_d = cnt_q + COUNT_W'(1);
        case (opcode)
          OP_LDR1: state_d = S_LDR11;
          OP_LDR2: state_d = S_LDR21;
          OP_STAC: state_d = S_STAC1;
          OP_ADD:  state_d = S_ADD;
          OP_MUL:  state_d = S_MUL;
          OP_END: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q;
          end
          default: begin
            state_d = S_IDLE;
            ill_d   = 1'b1;
            cnt_d   = cnt_q;
          end
        endcase
      end
      S_LDR11: state_d = S_LDR12;
      S_LDR12: state_d = S_LDR13;
      S_LDR13: state_d = S_LDR14;
      S_LDR14: state_d = S_F1;
      S_LDR21: state_d = S_LDR22;
      S_LDR22: state_d = S_LDR23;
      S_LDR23: state_d = S_LDR24;
      S_LDR24: state_d = S_F1;
      S_STAC1: state_d = S_STAC2;
      S_STAC2: state_d = S_STAC3;
      S_STAC3: state_d = S_STAC4;
      S_STAC4: state_d = S_F1;
      S_ADD:   state_d = S_ADD2;
      S_ADD2:  state_d = S_F1;
      S_MUL:   state_d = S_F1;
      // Unused codes recover quietly to idle.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign illegal     = ill_q;
  assign instr_count = cnt_q;

endmodule
